// File: rtl/mesi_line_tracker.sv
// MESI/MSI coherence state tracker for a direct-indexed line array; one request per cycle.
// Latency 1 (registered response), always ready; saturating hit/miss/writeback statistics.
module mesi_line_tracker #(
   parameter int NUM_LINES = 16,
   parameter bit ENABLE_E  = 1'b1,
   parameter int CNT_W     = 16,
   localparam int IDX_W    = ($clog2(NUM_LINES) < 1) ? 1 : $clog2(NUM_LINES)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   input  logic [2:0]       req_op,
   input  logic [IDX_W-1:0] req_idx,
   input  logic             shared_in,
   input  logic             clear_stats,
   output logic             rsp_valid,
   output logic [1:0]       rsp_prev,
   output logic [1:0]       rsp_next,
   output logic [1:0]       bus_op,
   output logic             bus_wb,
   output logic [1:0]       snoop_res,
   output logic             proto_err,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt,
   output logic [CNT_W-1:0] wb_cnt
);

   localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
   localparam logic [1:0] BUS_NONE = 2'd0, BUS_READ = 2'd1, BUS_RWIM = 2'd2, BUS_INV_WB = 2'd3;
   localparam logic [1:0] SN_NOHIT = 2'd0, SN_HIT = 2'd1, SN_HITM = 2'd2;

   typedef enum logic [2:0] {
      OP_PR_RD   = 3'd0,
      OP_PR_WR   = 3'd1,
      OP_SN_RD   = 3'd2,
      OP_SN_RWIM = 3'd3,
      OP_SN_INV  = 3'd4,
      OP_EVICT   = 3'd5
   } op_e;

   logic [1:0]       r_state [NUM_LINES];
   logic             r_rsp_valid, r_bus_wb, r_proto_err;
   logic [1:0]       r_rsp_prev, r_rsp_next, r_bus_op, r_snoop_res;
   logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

   logic       w_idx_ok, w_legal, w_wb, w_err, w_hit, w_miss, w_wbi;
   logic [1:0] w_prev, w_next, w_bus, w_snp;

   assign w_idx_ok = ({1'b0, req_idx} < (IDX_W+1)'(NUM_LINES));

   always_comb begin
      w_prev  = w_idx_ok ? r_state[req_idx] : ST_I;
      w_next  = w_prev;
      w_bus   = BUS_NONE;
      w_wb    = 1'b0;
      w_snp   = SN_NOHIT;
      w_err   = 1'b0;
      w_hit   = 1'b0;
      w_miss  = 1'b0;
      w_wbi   = 1'b0;
      w_legal = w_idx_ok;
      case (req_op)
         OP_PR_RD: begin
            if (w_prev == ST_I) begin
               w_next = (ENABLE_E && !shared_in) ? ST_E : ST_S;
               w_bus  = BUS_READ;
               w_miss = 1'b1;
            end else begin
               w_hit = 1'b1;
            end
         end
         OP_PR_WR: begin
            w_next = ST_M;
            if (w_prev == ST_I) begin
               w_bus  = BUS_RWIM;
               w_miss = 1'b1;
            end else begin
               w_hit = 1'b1;
               if (w_prev == ST_S) w_bus = BUS_INV_WB;
            end
         end
         OP_SN_RD, OP_SN_RWIM: begin
            if (w_prev != ST_I) begin
               w_next = (req_op == OP_SN_RD) ? ST_S : ST_I;
               w_snp  = (w_prev == ST_M) ? SN_HITM : SN_HIT;
               if (w_prev == ST_M) begin
                  w_bus = BUS_INV_WB;
                  w_wb  = 1'b1;
                  w_wbi = 1'b1;
               end
            end
         end
         OP_SN_INV: begin
            // Exclusive/modified lines cannot legally be invalidated without a writeback
            if (w_prev == ST_S) begin
               w_next = ST_I;
               w_snp  = SN_HIT;
            end else if (w_prev != ST_I) begin
               w_err = 1'b1;
            end
         end
         OP_EVICT: begin
            w_next = ST_I;
            if (w_prev == ST_M) begin
               w_bus = BUS_INV_WB;
               w_wb  = 1'b1;
               w_wbi = 1'b1;
            end
         end
         default: w_legal = 1'b0;
      endcase
      if (!w_legal) begin
         w_prev = ST_I;
         w_next = ST_I;
         w_bus  = BUS_NONE;
         w_wb   = 1'b0;
         w_snp  = SN_NOHIT;
         w_err  = 1'b1;
         w_hit  = 1'b0;
         w_miss = 1'b0;
         w_wbi  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_LINES; i++) r_state[i] <= ST_I;
         r_rsp_valid <= 1'b0;
         r_rsp_prev  <= ST_I;
         r_rsp_next  <= ST_I;
         r_bus_op    <= BUS_NONE;
         r_bus_wb    <= 1'b0;
         r_snoop_res <= SN_NOHIT;
         r_proto_err <= 1'b0;
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
         r_wb_cnt    <= '0;
      end else begin
         r_rsp_valid <= req_valid;
         if (req_valid) begin
            if (w_legal) r_state[req_idx] <= w_next;
            r_rsp_prev  <= w_prev;
            r_rsp_next  <= w_next;
            r_bus_op    <= w_bus;
            r_bus_wb    <= w_wb;
            r_snoop_res <= w_snp;
            if (w_err) r_proto_err <= 1'b1;
         end
         if (clear_stats) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
         end else if (req_valid) begin
            if (w_hit  && r_hit_cnt  != '1) r_hit_cnt  <= r_hit_cnt  + 1'b1;
            if (w_miss && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
            if (w_wbi  && r_wb_cnt   != '1) r_wb_cnt   <= r_wb_cnt   + 1'b1;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_prev  = r_rsp_prev;
   assign rsp_next  = r_rsp_next;
   assign bus_op    = r_bus_op;
   assign bus_wb    = r_bus_wb;
   assign snoop_res = r_snoop_res;
   assign proto_err = r_proto_err;
   assign hit_cnt   = r_hit_cnt;
   assign miss_cnt  = r_miss_cnt;
   assign wb_cnt    = r_wb_cnt;

endmodule

// File: tb/tb_mesi_line_tracker.sv
// Directed bench for mesi_line_tracker: default MESI build, an MSI build, and a small
// 5-line build with 2-bit counters, all driven from one shared request stream.
module tb_mesi_line_tracker;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [2:0] req_op = 3'd0;
   logic [3:0] req_idx = 4'd0;
   logic       shared_in = 1'b0;
   logic       clear_stats = 1'b0;

   always #5 clk = ~clk;

   logic        a_vld, a_wb, a_err;
   logic [1:0]  a_prev, a_next, a_bus, a_snp;
   logic [15:0] a_hit, a_miss, a_wbc;
   logic        m_vld, m_wb, m_err;
   logic [1:0]  m_prev, m_next, m_bus, m_snp;
   logic [15:0] m_hit, m_miss, m_wbc;
   logic        c_vld, c_wb, c_err;
   logic [1:0]  c_prev, c_next, c_bus, c_snp;
   logic [1:0]  c_hit, c_miss, c_wbc;

   mesi_line_tracker dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
      .req_idx(req_idx), .shared_in(shared_in), .clear_stats(clear_stats),
      .rsp_valid(a_vld), .rsp_prev(a_prev), .rsp_next(a_next), .bus_op(a_bus),
      .bus_wb(a_wb), .snoop_res(a_snp), .proto_err(a_err),
      .hit_cnt(a_hit), .miss_cnt(a_miss), .wb_cnt(a_wbc)
   );

   mesi_line_tracker #(.ENABLE_E(1'b0)) dut_msi (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
      .req_idx(req_idx), .shared_in(shared_in), .clear_stats(clear_stats),
      .rsp_valid(m_vld), .rsp_prev(m_prev), .rsp_next(m_next), .bus_op(m_bus),
      .bus_wb(m_wb), .snoop_res(m_snp), .proto_err(m_err),
      .hit_cnt(m_hit), .miss_cnt(m_miss), .wb_cnt(m_wbc)
   );

   mesi_line_tracker #(.NUM_LINES(5), .CNT_W(2)) dut_c2 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
      .req_idx(req_idx[2:0]), .shared_in(shared_in), .clear_stats(clear_stats),
      .rsp_valid(c_vld), .rsp_prev(c_prev), .rsp_next(c_next), .bus_op(c_bus),
      .bus_wb(c_wb), .snoop_res(c_snp), .proto_err(c_err),
      .hit_cnt(c_hit), .miss_cnt(c_miss), .wb_cnt(c_wbc)
   );

   int n_vec = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [2:0] op, input logic [3:0] idx, input logic sh, input logic clr);
      @(negedge clk);
      req_valid   = 1'b1;
      req_op      = op;
      req_idx     = idx;
      shared_in   = sh;
      clear_stats = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid   = 1'b0;
      clear_stats = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      req_valid   = 1'b0;
      clear_stats = 1'b0;
      reset_n     = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      do_reset();
      #1;
      chk("rst_vld", a_vld, 0);
      chk("rst_err", a_err, 0);
      chk("rst_prev_next", {a_prev, a_next, a_bus, a_snp}, 0);
      chk("rst_cnts", {a_hit, a_miss, a_wbc}, 0);

      // MESI transitions on the default build
      apply(3'd0, 4'd3, 1'b0, 1'b0);
      chk("rd_miss_vld", a_vld, 1);
      chk("rd_miss_st", {a_prev, a_next}, {2'd0, 2'd2});
      chk("rd_miss_bus", a_bus, 1);
      chk("rd_miss_cnt", a_miss, 1);
      apply(3'd1, 4'd3, 1'b0, 1'b0);
      chk("wr_e_st", {a_prev, a_next, a_bus}, {2'd2, 2'd3, 2'd0});
      chk("wr_e_hit", a_hit, 1);
      apply(3'd2, 4'd3, 1'b0, 1'b0);
      chk("snrd_m_st", {a_prev, a_next}, {2'd3, 2'd1});
      chk("snrd_m_snp", a_snp, 2);
      chk("snrd_m_bus", {a_bus, a_wb}, {2'd3, 1'b1});
      chk("snrd_m_wb", a_wbc, 1);
      chk("snrd_hit_unchanged", a_hit, 1);
      apply(3'd1, 4'd5, 1'b0, 1'b0);
      chk("wr_i", {a_prev, a_next, a_bus}, {2'd0, 2'd3, 2'd2});
      chk("wr_i_miss", a_miss, 2);
      apply(3'd5, 4'd5, 1'b0, 1'b0);
      chk("evict_m", {a_prev, a_next, a_bus, a_wb}, {2'd3, 2'd0, 2'd3, 1'b1});
      chk("evict_m_wb", a_wbc, 2);
      apply(3'd3, 4'd3, 1'b0, 1'b0);
      chk("rwim_s", {a_prev, a_next, a_bus, a_snp}, {2'd1, 2'd0, 2'd0, 2'd1});
      apply(3'd1, 4'd6, 1'b0, 1'b0);
      apply(3'd3, 4'd6, 1'b0, 1'b0);
      chk("rwim_m", {a_prev, a_next, a_bus, a_wb, a_snp}, {2'd3, 2'd0, 2'd3, 1'b1, 2'd2});
      chk("rwim_m_wb", a_wbc, 3);
      chk("rwim_m_miss", a_miss, 3);

      // MSI build never fills E
      apply(3'd0, 4'd0, 1'b0, 1'b0);
      chk("msi_rd", {m_prev, m_next, m_bus}, {2'd0, 2'd1, 2'd1});
      chk("mesi_rd_shared0", a_next, 2);
      apply(3'd1, 4'd0, 1'b0, 1'b0);
      chk("msi_wr_s", {m_prev, m_next, m_bus, m_wb}, {2'd1, 2'd3, 2'd3, 1'b0});
      chk("mesi_wr_e", {a_prev, a_next, a_bus}, {2'd2, 2'd3, 2'd0});
      chk("mesi_hit2", a_hit, 2);
      apply(3'd0, 4'd7, 1'b1, 1'b0);
      chk("rd_shared1", {a_prev, a_next}, {2'd0, 2'd1});

      // Illegal invalidate and reserved op
      apply(3'd4, 4'd0, 1'b0, 1'b0);
      chk("inv_m", {a_prev, a_next, a_snp}, {2'd3, 2'd3, 2'd0});
      chk("inv_m_err", a_err, 1);
      apply(3'd6, 4'd0, 1'b0, 1'b0);
      chk("rsvd", {a_vld, a_prev, a_next, a_bus}, {1'b1, 2'd0, 2'd0, 2'd0});
      idle();
      chk("idle_vld", a_vld, 0);
      chk("err_sticky", a_err, 1);
      apply(3'd0, 4'd0, 1'b0, 1'b0);
      chk("after_rsvd_st", {a_prev, a_next, a_bus}, {2'd3, 2'd3, 2'd0});

      // Saturating 2-bit counters and clear priority
      do_reset();
      #1;
      chk("rst_err_clr", {a_err, c_err}, 0);
      apply(3'd0, 4'd1, 1'b0, 1'b0);
      chk("c2_miss", c_miss, 1);
      apply(3'd0, 4'd1, 1'b0, 1'b0);
      apply(3'd0, 4'd1, 1'b0, 1'b0);
      apply(3'd0, 4'd1, 1'b0, 1'b0);
      chk("c2_hit3", c_hit, 3);
      apply(3'd0, 4'd1, 1'b0, 1'b0);
      chk("c2_hit_sat", c_hit, 3);
      apply(3'd0, 4'd1, 1'b0, 1'b1);
      chk("c2_clear", {c_hit, c_miss}, 0);
      apply(3'd2, 4'd1, 1'b0, 1'b0);
      chk("c2_snoop_hit", {c_prev, c_next, c_snp}, {2'd2, 2'd1, 2'd1});
      chk("c2_snoop_nocnt", c_hit, 0);
      apply(3'd0, 4'd6, 1'b0, 1'b0);
      chk("c2_oob", {c_vld, c_prev, c_next, c_bus}, {1'b1, 2'd0, 2'd0, 2'd0});
      chk("c2_oob_err", c_err, 1);
      chk("c2_oob_nocnt", c_miss, 0);

      // Reset arriving while a response is presented
      apply(3'd0, 4'd2, 1'b0, 1'b0);
      chk("pre_rst_vld", a_vld, 1);
      req_valid = 1'b0;
      reset_n   = 1'b0;
      #1;
      chk("async_rst_vld", a_vld, 0);
      @(negedge clk);
      reset_n = 1'b1;
      apply(3'd0, 4'd2, 1'b0, 1'b0);
      chk("post_rst_prev", {a_prev, a_next}, {2'd0, 2'd2});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
